pe_writeback: RTL and testbench
===============================

PE_WRITEBACK -- requirements
Module: pe_writeback

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, 32, RF write data width (matches DEF_PE_DATA_WIDTH).
REQ-002 SHALL have parameter: ADDR_WIDTH, 5, RF index width (matches DEF_RF_INDEX_WIDTH).
REQ-003 SHALL have parameter: LQ_DEPTH, 2, pending-load queue depth (power of two, >=2).
REQ-004 SHALL use one clock and a synchronous, active-high reset: iClk input 1 clock (all state on rising edge); iReset input 1 synchronous active-high reset.
REQ-005 iEX_Valid input 1: ALU result valid this cycle.
REQ-006 iEX_Result input DATA_WIDTH: ALU result.
REQ-007 iEX_RF_Write_Addr input ADDR_WIDTH: destination register of the ALU result or issued load.
REQ-008 iEX_Load_Issue input 1: load issued to LSU this cycle; destination is iEX_RF_Write_Addr.
REQ-009 iLSU_Valid input 1: load data returning this cycle, in issue order.
REQ-010 iLSU_Load_Data input DATA_WIDTH: returned load data.
REQ-011 oWB_RF_Write_Addr output ADDR_WIDTH: RF and bypass write address.
REQ-012 oWB_RF_Write_Data output DATA_WIDTH: RF and bypass write data.
REQ-013 oWB_RF_Write_Enable output 1: RF and bypass write strobe.
REQ-014 oStall output 1: EX must hold its inputs; asserted inputs are not consumed.
REQ-015 oLQ_Count output log2(LQ_DEPTH)+1: outstanding loads.
REQ-016 oError output 1: sticky protocol-error flag.

Function
REQ-017 SHALL drive oWB_RF_* from registers only; nothing on the RF write port is combinational from inputs.
REQ-018 SHALL use a single RF write port, so at most one write per cycle.
REQ-019 ALU path: iEX_Valid=1 and oStall=0 at cycle t -> write of iEX_Result to iEX_RF_Write_Addr at t+1; latency 1.
REQ-020 Load issue: iEX_Load_Issue=1 and oStall=0 -> push iEX_RF_Write_Addr into the FIFO load queue.
REQ-021 Load return: iLSU_Valid=1 at t with queue non-empty -> pop head; write iLSU_Load_Data to the head address at t+1.
REQ-022 Arbitration: a load return has priority over an ALU result in the same cycle.
REQ-023 Losing ALU result SHALL be captured in a 1-entry skid register; state moves RUN->HOLD.
REQ-024 In HOLD, with no load return, the skid entry SHALL be written next cycle; state returns to RUN.
REQ-025 In HOLD, if a load return arrives, the load wins again; the skid entry SHALL be retained and state stays HOLD.
REQ-026 oStall = (state==HOLD) | (oLQ_Count==LQ_DEPTH), decoded from registered state only.
REQ-027 While oStall=1, iEX_Valid and iEX_Load_Issue SHALL be ignored; no push, no capture.
REQ-028 Same-cycle push and pop with the queue not full SHALL be legal; count unchanged; FIFO order preserved.
REQ-029 Queue pointers SHALL wrap modulo LQ_DEPTH.
REQ-030 Addresses 0 and 1 are read-only: any write targeting them SHALL produce oWB_RF_Write_Enable=0, still consuming the ALU result or popping the load.
REQ-031 iLSU_Valid=1 with an empty queue SHALL discard the data, make no write, and set oError; oError clears only on reset.
REQ-032 iEX_Valid and iEX_Load_Issue are mutually exclusive; both high SHALL set oError and treat the cycle as a load issue only.

Reset
REQ-033 iReset=1 at a clock edge SHALL set: state RUN; queue empty (oLQ_Count=0); skid empty; oWB_RF_Write_Enable=0, oWB_RF_Write_Addr=0, oWB_RF_Write_Data=0; oStall=0; oError=0.
REQ-034 Reset SHALL take precedence over every simultaneous input; outstanding loads and the skid entry are dropped.
REQ-035 After reset, returns for loads issued before reset SHALL be treated per REQ-031.

Verification
REQ-036 ALU only: iEX_Valid=1, addr=5, result=0x1234 at t -> t+1: Enable=1, Addr=5, Data=0x1234; oStall=0.
REQ-037 Conflict:
- t: load issued to r7; t+3: iLSU_Valid=1 data 0xAAAA together with ALU r9=0x5555.
- t+4: write r7=0xAAAA; oStall=1.
- t+5: write r9=0x5555; oStall=0.
REQ-038 Queue full:
- Two loads issued (r2, r3) -> oLQ_Count=2, oStall=1, third issue ignored.
- Returns 0x11 then 0x22 -> writes r2=0x11, r3=0x22 in order; oStall drops when count<2.
REQ-039 Read-only target: ALU write to r1=0xFFFF -> Enable stays 0. Load to r0 -> popped, oLQ_Count decrements, no write.
REQ-040 Error and reset:
- iLSU_Valid=1 with empty queue -> oError=1, no write.
- Then one load outstanding plus iReset=1 mid-operation -> next cycle all outputs 0, oLQ_Count=0.

Source files
------------

// File: rtl/pe_writeback.sv
// ============================================================================
//  Module      : pe_writeback
//  Description : Single-port register-file writeback stage. Merges ALU results
//                and in-order load returns, with a pending-load FIFO and a
//                1-entry skid register for ALU results that lose arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int LQ_DEPTH   = 2
) (
    input  logic                        iClk,
    input  logic                        iReset,
    input  logic                        iEX_Valid,
    input  logic [DATA_WIDTH-1:0]       iEX_Result,
    input  logic [ADDR_WIDTH-1:0]       iEX_RF_Write_Addr,
    input  logic                        iEX_Load_Issue,
    input  logic                        iLSU_Valid,
    input  logic [DATA_WIDTH-1:0]       iLSU_Load_Data,
    output logic [ADDR_WIDTH-1:0]       oWB_RF_Write_Addr,
    output logic [DATA_WIDTH-1:0]       oWB_RF_Write_Data,
    output logic                        oWB_RF_Write_Enable,
    output logic                        oStall,
    output logic [$clog2(LQ_DEPTH):0]   oLQ_Count,
    output logic                        oError
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LQ_FULL = CNT_W'(LQ_DEPTH);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 next_state;

    logic [ADDR_WIDTH-1:0]  lq_addr [LQ_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       lq_count;
    logic [CNT_W-1:0]       lq_count_nxt;

    logic [ADDR_WIDTH-1:0]  skid_addr;
    logic [DATA_WIDTH-1:0]  skid_data;

    logic [ADDR_WIDTH-1:0]  wb_addr;
    logic [DATA_WIDTH-1:0]  wb_data;
    logic                   wb_en;
    logic                   error;

    logic                   stall;
    logic                   push;
    logic                   pop;
    logic                   accept_alu;
    logic                   lsu_orphan;
    logic                   dual_issue;
    logic                   skid_load;
    logic                   do_write;
    logic [ADDR_WIDTH-1:0]  wb_addr_nxt;
    logic [DATA_WIDTH-1:0]  wb_data_nxt;
    logic                   wb_en_nxt;

    // Stall depends only on registered state so EX never sees a comb loop.
    assign stall      = (state == ST_HOLD) || (lq_count == LQ_FULL);
    assign push       = iEX_Load_Issue && !stall;
    assign accept_alu = iEX_Valid && !iEX_Load_Issue && !stall;
    assign dual_issue = iEX_Valid && iEX_Load_Issue && !stall;
    assign pop        = iLSU_Valid && (lq_count != '0);
    assign lsu_orphan = iLSU_Valid && (lq_count == '0);

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Load return always wins the single write port; ALU falls back to skid.
    always_comb begin
        next_state  = state;
        skid_load   = 1'b0;
        do_write    = 1'b0;
        wb_addr_nxt = wb_addr;
        wb_data_nxt = wb_data;
        if (pop) begin
            do_write    = 1'b1;
            wb_addr_nxt = lq_addr[rd_ptr];
            wb_data_nxt = iLSU_Load_Data;
            if (accept_alu) begin
                skid_load  = 1'b1;
                next_state = ST_HOLD;
            end
        end else if (state == ST_HOLD) begin
            do_write    = 1'b1;
            wb_addr_nxt = skid_addr;
            wb_data_nxt = skid_data;
            next_state  = ST_RUN;
        end else if (accept_alu) begin
            do_write    = 1'b1;
            wb_addr_nxt = iEX_RF_Write_Addr;
            wb_data_nxt = iEX_Result;
        end
        // r0 and r1 are read-only: the slot is consumed but no strobe issued.
        wb_en_nxt = do_write && (|wb_addr_nxt[ADDR_WIDTH-1:1]);
    end

    always_comb begin
        lq_count_nxt = lq_count;
        case ({push, pop})
            2'b10:   lq_count_nxt = lq_count + CNT_W'(1);
            2'b01:   lq_count_nxt = lq_count - CNT_W'(1);
            default: lq_count_nxt = lq_count;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            lq_count  <= '0;
            skid_addr <= '0;
            skid_data <= '0;
            wb_addr   <= '0;
            wb_data   <= '0;
            wb_en     <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            lq_count <= lq_count_nxt;
            if (skid_load) begin
                skid_addr <= iEX_RF_Write_Addr;
                skid_data <= iEX_Result;
            end
            wb_addr <= wb_addr_nxt;
            wb_data <= wb_data_nxt;
            wb_en   <= wb_en_nxt;
            error   <= error || lsu_orphan || dual_issue;
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge iClk) begin
        if (push) begin
            lq_addr[wr_ptr] <= iEX_RF_Write_Addr;
        end
    end

    assign oWB_RF_Write_Addr   = wb_addr;
    assign oWB_RF_Write_Data   = wb_data;
    assign oWB_RF_Write_Enable = wb_en;
    assign oStall              = stall;
    assign oLQ_Count           = lq_count;
    assign oError              = error;

endmodule

`default_nettype wire

// File: tb/tb_pe_writeback.sv
// ============================================================================
//  Module      : tb_pe_writeback
//  Description : Self-checking bench for pe_writeback using a write scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_writeback;

    logic        iClk = 1'b0;
    logic        iReset;
    logic        iEX_Valid;
    logic [31:0] iEX_Result;
    logic [4:0]  iEX_RF_Write_Addr;
    logic        iEX_Load_Issue;
    logic        iLSU_Valid;
    logic [31:0] iLSU_Load_Data;
    logic [4:0]  oWB_RF_Write_Addr;
    logic [31:0] oWB_RF_Write_Data;
    logic        oWB_RF_Write_Enable;
    logic        oStall;
    logic [1:0]  oLQ_Count;
    logic        oError;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    pe_writeback #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .LQ_DEPTH   (2)
    ) dut (
        .iClk                (iClk),
        .iReset              (iReset),
        .iEX_Valid           (iEX_Valid),
        .iEX_Result          (iEX_Result),
        .iEX_RF_Write_Addr   (iEX_RF_Write_Addr),
        .iEX_Load_Issue      (iEX_Load_Issue),
        .iLSU_Valid          (iLSU_Valid),
        .iLSU_Load_Data      (iLSU_Load_Data),
        .oWB_RF_Write_Addr   (oWB_RF_Write_Addr),
        .oWB_RF_Write_Data   (oWB_RF_Write_Data),
        .oWB_RF_Write_Enable (oWB_RF_Write_Enable),
        .oStall              (oStall),
        .oLQ_Count           (oLQ_Count),
        .oError              (oError)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        iEX_Valid         = 1'b0;
        iEX_Result        = '0;
        iEX_RF_Write_Addr = '0;
        iEX_Load_Issue    = 1'b0;
        iLSU_Valid        = 1'b0;
        iLSU_Load_Data    = '0;
    endtask

    // Advance one cycle; any write strobe must match the scoreboard head.
    task automatic tick();
        wr_t e;
        @(posedge iClk);
        #1;
        if (oWB_RF_Write_Enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_en", 32'(oWB_RF_Write_Enable), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wb_addr", 32'(oWB_RF_Write_Addr), 32'(e.addr));
                check("wb_data", oWB_RF_Write_Data, e.data);
            end
        end
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        iEX_Valid = 1'b1; iEX_RF_Write_Addr = a; iEX_Result = d;
    endtask

    task automatic load_issue(input logic [4:0] a);
        iEX_Load_Issue = 1'b1; iEX_RF_Write_Addr = a;
    endtask

    task automatic lsu_ret(input logic [31:0] d);
        iLSU_Valid = 1'b1; iLSU_Load_Data = d;
    endtask

    initial begin
        idle_inputs();
        iReset = 1'b1;
        tick();
        tick();
        check("rst_en",    32'(oWB_RF_Write_Enable), 32'd0);
        check("rst_addr",  32'(oWB_RF_Write_Addr),   32'd0);
        check("rst_data",  oWB_RF_Write_Data,        32'd0);
        check("rst_stall", 32'(oStall),              32'd0);
        check("rst_count", 32'(oLQ_Count),           32'd0);
        check("rst_error", 32'(oError),              32'd0);
        iReset = 1'b0;
        tick();

        // ALU only, latency 1
        alu(5'd5, 32'h1234);
        exp_q.push_back('{addr: 5'd5, data: 32'h1234});
        tick();
        check("alu_en",    32'(oWB_RF_Write_Enable), 32'd1);
        check("alu_stall", 32'(oStall),              32'd0);
        idle_inputs();
        tick();
        check("alu_en_drop", 32'(oWB_RF_Write_Enable), 32'd0);

        // Load return collides with ALU result: load first, ALU via skid
        load_issue(5'd7);
        tick();
        idle_inputs();
        check("conf_count", 32'(oLQ_Count), 32'd1);
        tick();
        tick();
        lsu_ret(32'hAAAA);
        alu(5'd9, 32'h5555);
        exp_q.push_back('{addr: 5'd7, data: 32'hAAAA});
        exp_q.push_back('{addr: 5'd9, data: 32'h5555});
        tick();
        idle_inputs();
        check("conf_t4_en",    32'(oWB_RF_Write_Enable), 32'd1);
        check("conf_t4_stall", 32'(oStall),              32'd1);
        tick();
        check("conf_t5_en",    32'(oWB_RF_Write_Enable), 32'd1);
        check("conf_t5_stall", 32'(oStall),              32'd0);

        // Queue full: third issue ignored, returns in order
        load_issue(5'd2);
        tick();
        load_issue(5'd3);
        tick();
        check("full_count", 32'(oLQ_Count), 32'd2);
        check("full_stall", 32'(oStall),     32'd1);
        load_issue(5'd4);
        tick();
        check("full_ignored", 32'(oLQ_Count), 32'd2);
        idle_inputs();
        lsu_ret(32'h11);
        exp_q.push_back('{addr: 5'd2, data: 32'h11});
        tick();
        check("full_ret1_en",    32'(oWB_RF_Write_Enable), 32'd1);
        check("full_ret1_count", 32'(oLQ_Count),           32'd1);
        check("full_ret1_stall", 32'(oStall),              32'd0);
        lsu_ret(32'h22);
        exp_q.push_back('{addr: 5'd3, data: 32'h22});
        tick();
        idle_inputs();
        check("full_ret2_count", 32'(oLQ_Count), 32'd0);
        check("full_noerr",      32'(oError),    32'd0);

        // Same-cycle push and pop keeps count and order across pointer wrap
        load_issue(5'd10);
        tick();
        load_issue(5'd11);
        lsu_ret(32'h33);
        exp_q.push_back('{addr: 5'd10, data: 32'h33});
        tick();
        idle_inputs();
        check("pp_count", 32'(oLQ_Count), 32'd1);
        lsu_ret(32'h44);
        exp_q.push_back('{addr: 5'd11, data: 32'h44});
        tick();
        idle_inputs();
        check("pp_count2", 32'(oLQ_Count), 32'd0);

        // Read-only targets
        alu(5'd1, 32'hFFFF);
        tick();
        idle_inputs();
        check("ro_alu_en", 32'(oWB_RF_Write_Enable), 32'd0);
        load_issue(5'd0);
        tick();
        idle_inputs();
        check("ro_ld_count", 32'(oLQ_Count), 32'd1);
        lsu_ret(32'hBEEF);
        tick();
        idle_inputs();
        check("ro_ld_en",     32'(oWB_RF_Write_Enable), 32'd0);
        check("ro_ld_popped", 32'(oLQ_Count),           32'd0);
        check("ro_noerr",     32'(oError),              32'd0);

        // Orphan return sets sticky error
        lsu_ret(32'hDEAD);
        tick();
        idle_inputs();
        check("orph_en",  32'(oWB_RF_Write_Enable), 32'd0);
        check("orph_err", 32'(oError),              32'd1);
        tick();
        check("orph_sticky", 32'(oError), 32'd1);

        // Reset mid-operation with a load outstanding and an ALU write pending
        load_issue(5'd12);
        tick();
        idle_inputs();
        check("pre_rst_count", 32'(oLQ_Count), 32'd1);
        iReset = 1'b1;
        alu(5'd13, 32'h77);
        tick();
        idle_inputs();
        check("mid_rst_en",    32'(oWB_RF_Write_Enable), 32'd0);
        check("mid_rst_addr",  32'(oWB_RF_Write_Addr),   32'd0);
        check("mid_rst_data",  oWB_RF_Write_Data,        32'd0);
        check("mid_rst_count", 32'(oLQ_Count),           32'd0);
        check("mid_rst_stall", 32'(oStall),              32'd0);
        check("mid_rst_err",   32'(oError),              32'd0);
        iReset = 1'b0;

        // Return for a load issued before reset is an orphan
        lsu_ret(32'hCAFE);
        tick();
        idle_inputs();
        check("post_rst_en",  32'(oWB_RF_Write_Enable), 32'd0);
        check("post_rst_err", 32'(oError),              32'd1);

        // Dual issue flags error and acts as a load only
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        alu(5'd14, 32'h99);
        load_issue(5'd14);
        tick();
        idle_inputs();
        check("dual_en",    32'(oWB_RF_Write_Enable), 32'd0);
        check("dual_count", 32'(oLQ_Count),           32'd1);
        check("dual_err",   32'(oError),              32'd1);
        lsu_ret(32'h5A5A);
        exp_q.push_back('{addr: 5'd14, data: 32'h5A5A});
        tick();
        idle_inputs();
        tick();

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
